// File: rtl/hoplite_pkg.sv
// Hoplite PE controller shared definitions.
// Packet layout {y, x, msg} and TX FSM encoding.
package hoplite_pkg;

  typedef enum logic {
    TX_IDLE    = 1'b0,
    TX_PENDING = 1'b1
  } tx_state_e;

  localparam int MSG_LSB = 0;

  function automatic int pkt_bits(int cb, int mb);
    return 2 * cb + mb;
  endfunction

  function automatic int x_lsb(int mb);
    return mb;
  endfunction

  function automatic int y_lsb(int cb, int mb);
    return mb + cb;
  endfunction

endpackage

// File: rtl/hoplite_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers.
// Push on full succeeds only alongside a pop.
module hoplite_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             rd_en;
  logic             wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers, extra MSB tells full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/hoplite_pe_controller.sv
// Hoplite PE controller: stages packets into TX FIFO,
// loops back local traffic, and queues ejections in RX FIFO.
module hoplite_pe_controller
  import hoplite_pkg::*;
#(
  parameter int COORD_BITS   = 1,
  parameter int MESSAGE_BITS = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int X_COORD      = 0,
  parameter int Y_COORD      = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [COORD_BITS-1:0]   x_coord_in,
  input  logic                    x_coord_in_valid,
  input  logic [COORD_BITS-1:0]   y_coord_in,
  input  logic                    y_coord_in_valid,
  input  logic [MESSAGE_BITS-1:0] message_in,
  input  logic                    message_in_valid,
  input  logic                    packet_complete_in,
  output logic                    tx_busy,
  output logic [2*COORD_BITS+MESSAGE_BITS-1:0] router_out_packet,
  output logic                    router_out_valid,
  input  logic                    router_out_ready,
  input  logic [2*COORD_BITS+MESSAGE_BITS-1:0] router_in_packet,
  input  logic                    router_in_valid,
  output logic [MESSAGE_BITS-1:0] pe_message_out,
  output logic                    pe_message_valid,
  input  logic                    pe_message_read,
  output logic                    rx_overflow
);

  localparam int PW = pkt_bits(COORD_BITS, MESSAGE_BITS);
  localparam int XL = x_lsb(MESSAGE_BITS);
  localparam int YL = y_lsb(COORD_BITS, MESSAGE_BITS);

  tx_state_e state_q, state_d;

  logic [COORD_BITS-1:0]   x_q, y_q, x_eff, y_eff;
  logic [MESSAGE_BITS-1:0] msg_q, msg_eff;
  logic [PW-1:0]           pkt_new, pend_q;
  logic                    pend_load;

  logic          tx_push, tx_pop, tx_full, tx_empty, tx_space;
  logic [PW-1:0] tx_push_data, tx_head;
  logic          head_local;

  logic                    rx_push, rx_pop, rx_full, rx_empty;
  logic                    rx_space, loop_ok;
  logic [MESSAGE_BITS-1:0] rx_push_data;
  logic                    rx_coord_unused;

  assign rx_coord_unused = ^router_in_packet[PW-1:XL];

  assign x_eff   = x_coord_in_valid ? x_coord_in : x_q;
  assign y_eff   = y_coord_in_valid ? y_coord_in : y_q;
  assign msg_eff = message_in_valid ? message_in : msg_q;
  assign pkt_new = {y_eff, x_eff, msg_eff};

  assign head_local = !tx_empty &&
    (tx_head[XL +: COORD_BITS] == COORD_BITS'(X_COORD)) &&
    (tx_head[YL +: COORD_BITS] == COORD_BITS'(Y_COORD));

  assign router_out_packet = tx_head;
  assign router_out_valid  = !tx_empty && !head_local;

  assign rx_pop   = pe_message_read && !rx_empty;
  assign rx_space = !rx_full || rx_pop;
  assign loop_ok  = head_local && !router_in_valid && rx_space;
  assign rx_push  = router_in_valid || loop_ok;
  assign rx_push_data = router_in_valid ?
    router_in_packet[MSG_LSB +: MESSAGE_BITS] :
    tx_head[MSG_LSB +: MESSAGE_BITS];

  assign tx_pop   = (router_out_valid && router_out_ready) || loop_ok;
  assign tx_space = !tx_full || tx_pop;

  assign tx_busy          = (state_q == TX_PENDING);
  assign pe_message_valid = !rx_empty;

  // TX state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= TX_IDLE;
    else          state_q <= state_d;
  end

  // TX next-state: push directly or park the packet when full.
  always_comb begin
    state_d      = state_q;
    tx_push      = 1'b0;
    tx_push_data = pkt_new;
    pend_load    = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (packet_complete_in) begin
          if (tx_space) begin
            tx_push = 1'b1;
          end else begin
            pend_load = 1'b1;
            state_d   = TX_PENDING;
          end
        end
      end
      TX_PENDING: begin
        tx_push_data = pend_q;
        if (tx_space) begin
          tx_push = 1'b1;
          state_d = TX_IDLE;
        end
      end
    endcase
  end

  // Sticky staging registers; frozen while a packet is parked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      msg_q <= '0;
    end else if (state_q == TX_IDLE) begin
      x_q   <= x_eff;
      y_q   <= y_eff;
      msg_q <= msg_eff;
    end
  end

  // Parked packet waiting for TX space.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       pend_q <= '0;
    else if (pend_load) pend_q <= pkt_new;
  end

  // Sticky flag for ejections dropped on a full RX queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rx_overflow <= 1'b0;
    else if (router_in_valid && !rx_space)
      rx_overflow <= 1'b1;
  end

  hoplite_fifo #(
    .WIDTH(PW),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (tx_push),
    .push_data(tx_push_data),
    .pop      (tx_pop),
    .pop_data (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  hoplite_fifo #(
    .WIDTH(MESSAGE_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (rx_push),
    .push_data(rx_push_data),
    .pop      (rx_pop),
    .pop_data (pe_message_out),
    .full     (rx_full),
    .empty    (rx_empty)
  );

endmodule

// File: tb/tb_hoplite_pe_controller.sv
// Directed self-checking bench for hoplite_pe_controller.
// Node (0,0), 1-bit coordinates, 32-bit messages, depth 4.
module tb_hoplite_pe_controller;

  logic        clk;
  logic        reset_n;
  logic        x_coord_in, x_coord_in_valid;
  logic        y_coord_in, y_coord_in_valid;
  logic [31:0] message_in;
  logic        message_in_valid, packet_complete_in;
  logic        tx_busy;
  logic [33:0] router_out_packet;
  logic        router_out_valid, router_out_ready;
  logic [33:0] router_in_packet;
  logic        router_in_valid;
  logic [31:0] pe_message_out;
  logic        pe_message_valid, pe_message_read;
  logic        rx_overflow;

  int checks = 0;
  int errors = 0;

  hoplite_pe_controller dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .x_coord_in        (x_coord_in),
    .x_coord_in_valid  (x_coord_in_valid),
    .y_coord_in        (y_coord_in),
    .y_coord_in_valid  (y_coord_in_valid),
    .message_in        (message_in),
    .message_in_valid  (message_in_valid),
    .packet_complete_in(packet_complete_in),
    .tx_busy           (tx_busy),
    .router_out_packet (router_out_packet),
    .router_out_valid  (router_out_valid),
    .router_out_ready  (router_out_ready),
    .router_in_packet  (router_in_packet),
    .router_in_valid   (router_in_valid),
    .pe_message_out    (pe_message_out),
    .pe_message_valid  (pe_message_valid),
    .pe_message_read   (pe_message_read),
    .rx_overflow       (rx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    x_coord_in_valid   = 1'b0;
    y_coord_in_valid   = 1'b0;
    message_in_valid   = 1'b0;
    packet_complete_in = 1'b0;
    router_in_valid    = 1'b0;
    pe_message_read    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset_n = 1'b0;
    #3;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (router_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %0b want 0", router_out_valid);
    end
    checks++;
    if (pe_message_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pe_valid got %0b want 0", pe_message_valid);
    end
    checks++;
    if (tx_busy !== 1'b0 || rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%0b ovf=%0b want 0 0",
               tx_busy, rx_overflow);
    end
  endtask

  task automatic test_single();
    router_out_ready = 1'b1;
    x_coord_in = 1'b1; x_coord_in_valid = 1'b1;
    y_coord_in = 1'b0; y_coord_in_valid = 1'b1;
    message_in = 32'hDEADBEEF; message_in_valid = 1'b1;
    packet_complete_in = 1'b1;
    checks++;
    if (router_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pre got %0b want 0", router_out_valid);
    end
    tick();
    idle_inputs();
    checks++;
    if (router_out_valid !== 1'b1 ||
        router_out_packet !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_out got v=%0b p=%h want 1 %h",
               router_out_valid, router_out_packet,
               {1'b0, 1'b1, 32'hDEADBEEF});
    end
    tick();
    checks++;
    if (router_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_once got %0b want 0", router_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp;
    router_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      message_in = 32'hA0 + i; message_in_valid = 1'b1;
      packet_complete_in = 1'b1;
      if (i == 4) begin
        checks++;
        if (tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL bp_busy_early got %0b want 0", tx_busy);
        end
      end
      tick();
    end
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_busy got %0b want 1", tx_busy);
    end
    message_in = 32'hFF;
    tick();
    idle_inputs();
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_busy_hold got %0b want 1", tx_busy);
    end
    router_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp = {1'b0, 1'b1, 32'hA0 + i};
      checks++;
      if (router_out_valid !== 1'b1 || router_out_packet !== exp) begin
        errors++;
        $display("FAIL bp_order%0d got v=%0b p=%h want 1 %h",
                 i, router_out_valid, router_out_packet, exp);
      end
      tick();
      if (i == 0) begin
        checks++;
        if (tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL bp_busy_clear got %0b want 0", tx_busy);
        end
      end
    end
    checks++;
    if (router_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got %0b want 0", router_out_valid);
    end
  endtask

  task automatic test_loopback();
    router_out_ready = 1'b1;
    x_coord_in = 1'b0; x_coord_in_valid = 1'b1;
    y_coord_in = 1'b0; y_coord_in_valid = 1'b1;
    message_in = 32'h12; message_in_valid = 1'b1;
    packet_complete_in = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (router_out_valid !== 1'b0 || pe_message_valid !== 1'b0) begin
      errors++;
      $display("FAIL lb_n1 got out=%0b pe=%0b want 0 0",
               router_out_valid, pe_message_valid);
    end
    tick();
    checks++;
    if (router_out_valid !== 1'b0 || pe_message_valid !== 1'b1 ||
        pe_message_out !== 32'h12) begin
      errors++;
      $display("FAIL lb_n2 got out=%0b pe=%0b msg=%h want 0 1 12",
               router_out_valid, pe_message_valid, pe_message_out);
    end
    pe_message_read = 1'b1;
    tick();
    pe_message_read = 1'b0;
    checks++;
    if (pe_message_valid !== 1'b0) begin
      errors++;
      $display("FAIL lb_pop got %0b want 0", pe_message_valid);
    end
  endtask

  task automatic test_loopback_priority();
    message_in = 32'h56; message_in_valid = 1'b1;
    packet_complete_in = 1'b1;
    tick();
    idle_inputs();
    router_in_packet = {1'b0, 1'b0, 32'h34};
    router_in_valid = 1'b1;
    tick();
    router_in_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pe_message_valid !== 1'b1 ||
          pe_message_out !== (i == 0 ? 32'h34 : 32'h56)) begin
        errors++;
        $display("FAIL prio%0d got v=%0b msg=%h want 1 %h", i,
                 pe_message_valid, pe_message_out,
                 (i == 0 ? 32'h34 : 32'h56));
      end
      pe_message_read = 1'b1;
      tick();
      pe_message_read = 1'b0;
    end
    checks++;
    if (pe_message_valid !== 1'b0 || router_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_empty got pe=%0b out=%0b want 0 0",
               pe_message_valid, router_out_valid);
    end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < 5; i++) begin
      router_in_packet = {1'b1, 1'b1, 32'hB0 + i};
      router_in_valid = 1'b1;
      tick();
    end
    router_in_valid = 1'b0;
    checks++;
    if (rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %0b want 1", rx_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pe_message_valid !== 1'b1 || pe_message_out !== 32'hB0 + i) begin
        errors++;
        $display("FAIL ovf_data%0d got v=%0b msg=%h want 1 %h", i,
                 pe_message_valid, pe_message_out, 32'hB0 + i);
      end
      pe_message_read = 1'b1;
      tick();
      pe_message_read = 1'b0;
    end
    checks++;
    if (pe_message_valid !== 1'b0 || rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop got v=%0b ovf=%0b want 0 1",
               pe_message_valid, rx_overflow);
    end
    router_in_packet = {1'b0, 1'b0, 32'hBB};
    router_in_valid = 1'b1;
    tick();
    router_in_valid = 1'b0;
    do_reset();
    checks++;
    if (rx_overflow !== 1'b0 || pe_message_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reset got ovf=%0b v=%0b want 0 0",
               rx_overflow, pe_message_valid);
    end
  endtask

  task automatic test_rx_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      router_in_packet = {1'b0, 1'b0, 32'hC0 + i};
      router_in_valid = 1'b1;
      tick();
    end
    router_in_packet = {1'b0, 1'b0, 32'hC4};
    pe_message_read = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (rx_overflow !== 1'b0 || pe_message_out !== 32'hC1) begin
      errors++;
      $display("FAIL fpp_head got ovf=%0b msg=%h want 0 c1",
               rx_overflow, pe_message_out);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (pe_message_valid !== 1'b1 || pe_message_out !== 32'hC0 + i) begin
        errors++;
        $display("FAIL fpp_data%0d got v=%0b msg=%h want 1 %h", i,
                 pe_message_valid, pe_message_out, 32'hC0 + i);
      end
      pe_message_read = 1'b1;
      tick();
      pe_message_read = 1'b0;
    end
    checks++;
    if (pe_message_valid !== 1'b0) begin
      errors++;
      $display("FAIL fpp_empty got %0b want 0", pe_message_valid);
    end
  endtask

  task automatic test_reset_pending();
    router_out_ready = 1'b0;
    x_coord_in = 1'b1; x_coord_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      message_in = 32'hE0 + i; message_in_valid = 1'b1;
      packet_complete_in = 1'b1;
      tick();
    end
    idle_inputs();
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL rp_busy got %0b want 1", tx_busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (tx_busy !== 1'b0 || router_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_async got busy=%0b v=%0b want 0 0",
               tx_busy, router_out_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    router_out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (router_out_valid !== 1'b0 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rp_discard got v=%0b busy=%0b want 0 0",
               router_out_valid, tx_busy);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    x_coord_in = 1'b0;
    y_coord_in = 1'b0;
    message_in = '0;
    router_in_packet = '0;
    router_out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_backpressure();
    test_loopback();
    test_loopback_priority();
    test_rx_overflow();
    test_rx_full_push_pop();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hoplite_pe_controller.md
HOPLITE_PE_CONTROLLER -- requirements
Module: hoplite_pe_controller

Interface
REQ-001 SHALL have parameter COORD_BITS, default 1, meaning X/Y coordinate width.
REQ-002 SHALL have parameter MESSAGE_BITS, default 32, meaning payload width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning TX and RX FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameters X_COORD and Y_COORD, default 0, meaning this node's coordinates.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have x_coord_in  in  COORD_BITS  destination X; x_coord_in_valid  in  1  load strobe.
REQ-007 SHALL have y_coord_in  in  COORD_BITS  destination Y; y_coord_in_valid  in  1  load strobe.
REQ-008 SHALL have message_in  in  MESSAGE_BITS  payload; message_in_valid  in  1  load strobe; packet_complete_in  in  1  send strobe.
REQ-009 SHALL have tx_busy  out  1  packet pending; cannot accept a new packet.
REQ-010 SHALL have router_out_packet  out  2*COORD_BITS+MESSAGE_BITS  {y,x,msg}; router_out_valid  out  1; router_out_ready  in  1  injection grant.
REQ-011 SHALL have router_in_packet  in  2*COORD_BITS+MESSAGE_BITS; router_in_valid  in  1  ejection, no backpressure.
REQ-012 SHALL have pe_message_out  out  MESSAGE_BITS; pe_message_valid  out  1; pe_message_read  in  1  pop; rx_overflow  out  1  sticky drop flag.

Function
REQ-013 Staging registers x, y and msg SHALL load on their valid strobes and SHALL retain values until reloaded (sticky destination).
REQ-014 TX FSM states SHALL be IDLE and PENDING.
REQ-015 In IDLE, packet_complete_in with TX FIFO not full SHALL push {y,x,msg} in the same cycle, using a field strobed in that same cycle.
REQ-016 In IDLE, packet_complete_in with TX FIFO full SHALL latch the packet and enter PENDING; tx_busy = 1 in PENDING.
REQ-017 In PENDING, the latched packet SHALL be pushed on the first cycle the FIFO is not full (a same-cycle pop counts), then return to IDLE.
REQ-018 In PENDING, field strobes and packet_complete_in SHALL be ignored.
REQ-019 router_out_valid SHALL equal TX-not-empty, and router_out_packet SHALL be the head (first-word fall-through); the head SHALL pop when router_out_valid && router_out_ready.
REQ-020 A head whose destination equals (X_COORD,Y_COORD) SHALL be looped back into the RX FIFO instead of injected; router_out_valid = 0 for it.
REQ-021 Loopback SHALL pop the head only if the RX push succeeds that cycle; router_in_valid SHALL take priority, and loopback SHALL retry next cycle.
REQ-022 router_in_valid SHALL push the message field into the RX FIFO.
REQ-023 A push to a full RX FIFO without a same-cycle pop SHALL be dropped and SHALL set rx_overflow until reset.
REQ-024 pe_message_valid SHALL equal RX-not-empty, and pe_message_out SHALL be the head; pe_message_read on empty SHALL be ignored.
REQ-025 Latency SHALL be: complete at cycle N gives router_out_valid at N+1; router_in_valid at N gives pe_message_valid at N+1.
REQ-026 Simultaneous push and pop on a full FIFO SHALL both succeed, leaving occupancy unchanged.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH, using an extra MSB for full/empty detection.

Reset
REQ-028 reset_n low SHALL asynchronously clear both FIFOs, staging registers, rx_overflow and tx_busy, and set the FSM to IDLE; router_out_valid and pe_message_valid SHALL then read 0.
REQ-029 Reset mid-PENDING SHALL discard the latched packet.

Structure
REQ-030 Packet field widths, field offsets, and the FSM state encodings SHALL reside in shared package hoplite_pkg.
REQ-031 Both queues SHALL instantiate one sub-module, hoplite_fifo (parameterised WIDTH and DEPTH; FWFT; full/empty outputs).

Verification
REQ-032 Load x=1, y=0, msg=0xDEADBEEF, complete, with router_out_ready=1 -> router_out_packet={0,1,0xDEADBEEF}, valid for exactly 1 cycle at N+1.
REQ-033 router_out_ready=0; send 5 packets with DEPTH=4 -> the 5th sets tx_busy; ready=1 -> all 5 emerge in order and tx_busy clears.
REQ-034 Send to (0,0) from node (0,0) with msg=0x12 -> router_out_valid stays 0 and pe_message_out=0x12 at N+2.
REQ-035 Loopback and router_in_valid (msg 0x34) in the same cycle -> RX order is 0x34, then the loopback message.
REQ-036 Five router_in_valid pulses, no reads -> 4 entries stored, 5th dropped, rx_overflow=1; reset -> all cleared.
REQ-037 Full RX with router_in_valid and pe_message_read in the same cycle -> no drop, occupancy stays 4, rx_overflow stays 0.
